al4s3b_wb_counter_regs: RTL and testbench

//  Wishbone client register block that owns the 32-bit free-running counter driven onto the fabric cnt_out pins.

---
 rtl/al4s3b_counter_pkg.sv | 27 ++
 rtl/al4s3b_cnt32_core.sv | 36 +++
 rtl/al4s3b_wb_counter_regs.sv | 127 ++++++++++++
 tb/tb_al4s3b_wb_counter_regs.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/al4s3b_counter_pkg.sv
// Shared constants for the Wishbone counter register block: register map,
// control/status bit positions and the filler value for unmapped reads.
package al4s3b_counter_pkg;

    localparam int unsigned ADR_ID      = 0;
    localparam int unsigned ADR_REV     = 1;
    localparam int unsigned ADR_SET_RST = 2;
    localparam int unsigned ADR_EN      = 3;
    localparam int unsigned ADR_ERR     = 4;
    localparam int unsigned ADR_CNT     = 5;
    localparam int unsigned ADR_DEBUG   = 6;

    localparam int CLR_BIT  = 0;
    localparam int LOAD_BIT = 1;
    localparam int EN_BIT   = 0;
    localparam int SAT_BIT  = 1;
    localparam int OVF_BIT  = 0;
    localparam int ILL_BIT  = 1;

    localparam logic [31:0] DEF_REG_VALUE = 32'hFABD_EFAC;

    // SET_RST is write-only but still a legal target; ID/REV and holes are not.
    function automatic logic reg_writable(input int unsigned adr);
        return (adr >= ADR_SET_RST) && (adr <= ADR_DEBUG);
    endfunction

endpackage

// File: rtl/al4s3b_cnt32_core.sv
// Free-running counter datapath: clear > load > increment > hold, with
// optional saturation at all-ones and a pulse on every wrap/saturate event.
module al4s3b_cnt32_core #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_sat,
    output logic [W-1:0] o_count,
    output logic         o_wrap_pulse
);
    logic [W-1:0] r_cnt;
    logic         w_at_max;

    assign w_at_max     = &r_cnt;
    // Clear/load take the cycle, so no overflow is flagged when they coincide.
    assign o_wrap_pulse = i_en & w_at_max & ~i_clr & ~i_load;
    assign o_count      = r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && !(w_at_max && i_sat)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/al4s3b_wb_counter_regs.sv
// Wishbone client owning the 32-bit fabric counter: ID/REV, enable, clear/load,
// preload, sticky RW1C error status and a debug scratch register.
module al4s3b_wb_counter_regs #(
    parameter int              ADDRWIDTH     = 7,
    parameter int              DATAWIDTH     = 32,
    parameter logic [15:0]     DEVICE_ID     = 16'h0,
    parameter logic [31:0]     REV_LEVEL     = 32'h0,
    parameter logic [DATAWIDTH-1:0] DEF_REG_VALUE = al4s3b_counter_pkg::DEF_REG_VALUE
) (
    input  logic                   WB_CLK,
    input  logic                   WB_RST_N,
    input  logic [ADDRWIDTH-1:0]   WBs_ADR,
    input  logic                   WBs_CYC,
    input  logic                   WBs_STB,
    input  logic                   WBs_WE,
    input  logic [DATAWIDTH/8-1:0] WBs_BYTE_STB,
    input  logic [DATAWIDTH-1:0]   WBs_WR_DAT,
    output logic [DATAWIDTH-1:0]   WBs_RD_DAT,
    output logic                   WBs_ACK,
    output logic [DATAWIDTH-1:0]   count,
    output logic [31:0]            Device_ID
);
    import al4s3b_counter_pkg::*;

    logic                 r_ack;
    logic [DATAWIDTH-1:0] r_rd_dat;
    logic [1:0]           r_en;
    logic [1:0]           r_err;
    logic [DATAWIDTH-1:0] r_preload;
    logic [DATAWIDTH-1:0] r_debug;
    logic                 r_clr;
    logic                 r_load;

    int unsigned          w_adr;
    logic                 w_req, w_wr;
    logic                 w_wr_set, w_wr_en, w_wr_err, w_wr_cnt, w_wr_dbg, w_wr_ill;
    logic                 w_wrap;
    logic [1:0]           w_err_nxt;
    logic [DATAWIDTH-1:0] w_rd_mux;
    logic [DATAWIDTH-1:0] w_count;

    function automatic logic [DATAWIDTH-1:0] f_merge(
        input logic [DATAWIDTH-1:0]   old_v,
        input logic [DATAWIDTH-1:0]   new_v,
        input logic [DATAWIDTH/8-1:0] be
    );
        f_merge = old_v;
        for (int b = 0; b < DATAWIDTH/8; b++)
            if (be[b]) f_merge[8*b +: 8] = new_v[8*b +: 8];
    endfunction

    // Masking with ~ACK turns a held strobe into one ACK every other cycle.
    assign w_adr    = 32'(WBs_ADR);
    assign w_req    = WBs_CYC & WBs_STB & ~r_ack;
    assign w_wr     = w_req & WBs_WE;
    assign w_wr_set = w_wr & (w_adr == ADR_SET_RST) & WBs_BYTE_STB[0];
    assign w_wr_en  = w_wr & (w_adr == ADR_EN) & WBs_BYTE_STB[0];
    assign w_wr_err = w_wr & (w_adr == ADR_ERR) & WBs_BYTE_STB[0];
    assign w_wr_cnt = w_wr & (w_adr == ADR_CNT);
    assign w_wr_dbg = w_wr & (w_adr == ADR_DEBUG);
    assign w_wr_ill = w_wr & ~reg_writable(w_adr);

    assign WBs_ACK    = r_ack;
    assign WBs_RD_DAT = r_rd_dat;
    assign count      = w_count;
    assign Device_ID  = {16'h0, DEVICE_ID};

    always_comb begin
        w_rd_mux = DEF_REG_VALUE;
        case (w_adr)
            ADR_ID:      w_rd_mux = DATAWIDTH'({16'h0, DEVICE_ID});
            ADR_REV:     w_rd_mux = DATAWIDTH'(REV_LEVEL);
            ADR_SET_RST: w_rd_mux = '0;
            ADR_EN:      w_rd_mux = DATAWIDTH'(r_en);
            ADR_ERR:     w_rd_mux = DATAWIDTH'(r_err);
            ADR_CNT:     w_rd_mux = w_count;
            ADR_DEBUG:   w_rd_mux = r_debug;
            default:     ;
        endcase
    end

    // New error events override a same-cycle write-one-to-clear.
    always_comb begin
        w_err_nxt = r_err;
        if (w_wr_err) w_err_nxt = r_err & ~WBs_WR_DAT[1:0];
        if (w_wrap)   w_err_nxt[OVF_BIT] = 1'b1;
        if (w_wr_ill) w_err_nxt[ILL_BIT] = 1'b1;
    end

    always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
        if (!WB_RST_N) begin
            r_ack     <= 1'b0;
            r_rd_dat  <= '0;
            r_en      <= '0;
            r_err     <= '0;
            r_preload <= '0;
            r_debug   <= '0;
            r_clr     <= 1'b0;
            r_load    <= 1'b0;
        end else begin
            r_ack  <= w_req;
            r_clr  <= w_wr_set & WBs_WR_DAT[CLR_BIT];
            r_load <= w_wr_set & WBs_WR_DAT[LOAD_BIT];
            r_err  <= w_err_nxt;
            if (w_req)    r_rd_dat  <= w_rd_mux;
            if (w_wr_cnt) r_preload <= f_merge(r_preload, WBs_WR_DAT, WBs_BYTE_STB);
            if (w_wr_dbg) r_debug   <= f_merge(r_debug, WBs_WR_DAT, WBs_BYTE_STB);
            if (w_wr_en) begin
                r_en[EN_BIT]  <= WBs_WR_DAT[EN_BIT];
                r_en[SAT_BIT] <= WBs_WR_DAT[SAT_BIT];
            end
        end
    end

    al4s3b_cnt32_core #(.W(DATAWIDTH)) u_core (
        .i_clk        (WB_CLK),
        .i_rst_n      (WB_RST_N),
        .i_clr        (r_clr),
        .i_load       (r_load),
        .i_load_val   (r_preload),
        .i_en         (r_en[EN_BIT]),
        .i_sat        (r_en[SAT_BIT]),
        .o_count      (w_count),
        .o_wrap_pulse (w_wrap)
    );

endmodule

// File: tb/tb_al4s3b_wb_counter_regs.sv
// Scoreboard bench: the driver predicts each ACK edge and read value from a
// time-based counter model; a negedge monitor pops and compares every ACK.
module tb_al4s3b_wb_counter_regs;

    localparam logic [15:0] DEV  = 16'hC0DE;
    localparam logic [31:0] REV  = 32'h0001_0203;
    localparam logic [31:0] DEF  = 32'hFABD_EFAC;
    localparam longint      MAXV = 64'h0000_0000_FFFF_FFFF;

    logic        WB_CLK, WB_RST_N;
    logic [6:0]  WBs_ADR;
    logic        WBs_CYC, WBs_STB, WBs_WE;
    logic [3:0]  WBs_BYTE_STB;
    logic [31:0] WBs_WR_DAT, WBs_RD_DAT, count, Device_ID;
    logic        WBs_ACK;

    al4s3b_wb_counter_regs #(
        .ADDRWIDTH(7), .DATAWIDTH(32), .DEVICE_ID(DEV), .REV_LEVEL(REV), .DEF_REG_VALUE(DEF)
    ) dut (
        .WB_CLK(WB_CLK), .WB_RST_N(WB_RST_N), .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC),
        .WBs_STB(WBs_STB), .WBs_WE(WBs_WE), .WBs_BYTE_STB(WBs_BYTE_STB),
        .WBs_WR_DAT(WBs_WR_DAT), .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK),
        .count(count), .Device_ID(Device_ID)
    );

    typedef struct {
        bit          rd;
        logic [31:0] data;
        longint      edg;
        string       name;
    } exp_t;

    exp_t   sbq[$];
    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;

    // Counter model: value after edge k is base advanced by (k - t0) edges
    // of the enable/saturate settings in force since edge t0.
    bit          m_en, m_sat, m_ovf, m_ill;
    longint      m_base, m_t0;
    logic [31:0] m_pre, m_dbg;

    initial WB_CLK = 1'b0;
    always #5 WB_CLK = ~WB_CLK;

    initial forever begin
        @(posedge WB_CLK);
        cyc = cyc + 1;
    end

    function automatic longint mval(input longint k);
        longint s;
        if (!m_en || k <= m_t0) return m_base;
        s = m_base + (k - m_t0);
        if (m_sat) return (s > MAXV) ? MAXV : s;
        return s & MAXV;
    endfunction

    // True when some edge in (t0, b] saw the counter at all-ones while enabled.
    function automatic bit any_wrap(input longint b);
        return m_en && (b > m_t0) && (m_base + (b - 1 - m_t0) >= MAXV);
    endfunction

    function automatic void rebase(input longint k);
        if (any_wrap(k)) m_ovf = 1'b1;
        m_base = mval(k);
        m_t0   = k;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rd_exp(input logic [6:0] adr, input longint e);
        case (adr)
            7'd0:    return {16'h0, DEV};
            7'd1:    return REV;
            7'd2:    return 32'h0;
            7'd3:    return {30'h0, m_sat, m_en};
            7'd4:    return {30'h0, m_ill, m_ovf | any_wrap(e - 1)};
            7'd5:    return 32'(mval(e - 1));
            7'd6:    return m_dbg;
            default: return DEF;
        endcase
    endfunction

    function automatic void model_write(input logic [6:0] adr, input logic [31:0] d,
                                        input logic [3:0] be, input longint w);
        case (adr)
            7'd2: if (be[0] && (d[0] || d[1])) begin
                rebase(w);
                m_t0   = w + 1;
                m_base = d[0] ? 64'd0 : longint'(m_pre);
            end
            7'd3: if (be[0]) begin
                rebase(w);
                m_en  = d[0];
                m_sat = d[1];
            end
            7'd4: if (be[0]) begin
                rebase(w - 1);
                if (d[0]) m_ovf = 1'b0;
                if (d[1]) m_ill = 1'b0;
                rebase(w);
            end
            7'd5: m_pre = merge(m_pre, d, be);
            7'd6: m_dbg = merge(m_dbg, d, be);
            default: m_ill = 1'b1;
        endcase
    endfunction

    task automatic reset_model();
        m_en = 0; m_sat = 0; m_ovf = 0; m_ill = 0;
        m_base = 0; m_t0 = cyc; m_pre = '0; m_dbg = '0;
    endtask

    // Issued one cycle after the previous ACK has cleared, so the request is
    // taken at the very next edge.
    task automatic bus(input bit we, input logic [6:0] adr, input logic [31:0] dat,
                       input logic [3:0] be, input string nm);
        exp_t e;
        bit   got;
        e.rd   = !we;
        e.edg  = cyc + 1;
        e.name = nm;
        e.data = '0;
        if (we) model_write(adr, dat, be, e.edg);
        else    e.data = rd_exp(adr, e.edg);
        sbq.push_back(e);
        WBs_ADR = adr; WBs_WR_DAT = dat; WBs_BYTE_STB = be; WBs_WE = we;
        WBs_CYC = 1'b1; WBs_STB = 1'b1;
        got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge WB_CLK); #1;
            got = WBs_ACK;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL ack_timeout %s: no ACK within 4 cycles, required one", nm);
        end
        WBs_CYC = 1'b0; WBs_STB = 1'b0; WBs_WE = 1'b0;
        @(posedge WB_CLK); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge WB_CLK); #1; end
    endtask

    task automatic chk_cnt(input int n, input string nm);
        logic [31:0] v;
        repeat (n) begin
            @(posedge WB_CLK); #1;
            v = 32'(mval(cyc));
            total++;
            if (count !== v) begin
                bad++;
                $display("FAIL %s cyc=%0d: count=%h required %h", nm, cyc, count, v);
            end
        end
    endtask

    task automatic chk_now(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    initial begin
        exp_t e;
        bit   prev_ack = 0;
        forever begin
            @(negedge WB_CLK);
            if (prev_ack) chk_now("ack_width", 32'(WBs_ACK), 32'd0);
            if (WBs_ACK === 1'b1) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ack cyc=%0d: ACK with empty scoreboard", cyc);
                end else begin
                    e = sbq.pop_front();
                    total++;
                    if (cyc != e.edg) begin
                        bad++;
                        $display("FAIL ack_edge %s: ACK at edge %0d required %0d", e.name, cyc, e.edg);
                    end
                    if (e.rd) chk_now(e.name, WBs_RD_DAT, e.data);
                end
            end
            prev_ack = (WBs_ACK === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          op;
        logic [6:0]  a;
        WB_RST_N = 0; WBs_ADR = '0; WBs_CYC = 0; WBs_STB = 0; WBs_WE = 0;
        WBs_BYTE_STB = '0; WBs_WR_DAT = '0;
        repeat (3) @(posedge WB_CLK);
        #1;
        chk_now("rst_ack", 32'(WBs_ACK), 32'd0);
        chk_now("rst_rd_dat", WBs_RD_DAT, 32'd0);
        chk_now("rst_count", count, 32'd0);
        chk_now("device_id", Device_ID, {16'h0, DEV});
        WB_RST_N = 1;
        reset_model();

        bus(0, 7'h00, 0, 4'hF, "rd_id");
        bus(0, 7'h01, 0, 4'hF, "rd_rev");
        bus(0, 7'h7F, 0, 4'hF, "rd_undef_7f");
        bus(0, 7'h07, 0, 4'hF, "rd_undef_07");
        bus(0, 7'h02, 0, 4'hF, "rd_set_rst");

        bus(1, 7'h03, 32'h1, 4'hF, "wr_en1");
        idle(100);
        bus(1, 7'h03, 32'h0, 4'hF, "wr_en0");
        bus(0, 7'h05, 0, 4'hF, "rd_cnt_a");
        bus(0, 7'h05, 0, 4'hF, "rd_cnt_b");

        bus(1, 7'h05, 32'hFFFF_FFFD, 4'hF, "wr_preload");
        bus(1, 7'h02, 32'h2, 4'hF, "wr_load");
        bus(1, 7'h03, 32'h1, 4'hF, "wr_en_wrap");
        chk_cnt(4, "cnt_wrap");
        bus(0, 7'h04, 0, 4'hF, "rd_err_ovf");
        bus(1, 7'h04, 32'h1, 4'hF, "w1c_ovf");
        bus(0, 7'h04, 0, 4'hF, "rd_err_clr");

        bus(1, 7'h03, 32'h0, 4'hF, "wr_en_off");
        bus(1, 7'h02, 32'h2, 4'hF, "wr_load2");
        bus(1, 7'h04, 32'h3, 4'hF, "w1c_all");
        bus(1, 7'h03, 32'h3, 4'hF, "wr_en_sat");
        chk_cnt(5, "cnt_sat");
        bus(0, 7'h04, 0, 4'hF, "rd_err_sat");
        bus(0, 7'h05, 0, 4'hF, "rd_cnt_sat");

        bus(1, 7'h03, 32'h1, 4'hF, "wr_en_run");
        idle(3);
        bus(1, 7'h02, 32'h3, 4'hF, "wr_clr_load");
        chk_cnt(2, "cnt_clr_wins");
        bus(1, 7'h00, 32'hDEAD_BEEF, 4'hF, "wr_id_ill");
        bus(0, 7'h04, 0, 4'hF, "rd_err_ill");
        bus(0, 7'h00, 0, 4'hF, "rd_id_after");

        bus(1, 7'h06, 32'h0, 4'hF, "wr_dbg0");
        bus(1, 7'h06, 32'h1234_5678, 4'b0101, "wr_dbg_be");
        bus(0, 7'h06, 0, 4'hF, "rd_dbg_be");

        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: begin
                    a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7));
                    bus(0, a, 0, 4'hF, "rnd_rd");
                end
                1: bus(0, $urandom_range(0, 1) ? 7'h05 : 7'h04, 0, 4'hF, "rnd_rd_cnt_err");
                2: bus(1, 7'h03, 32'($urandom_range(0, 3)), 4'($urandom), "rnd_wr_en");
                3: bus(1, 7'h05, $urandom_range(0, 1) ? 32'hFFFF_FFFF - $urandom_range(0, 12) : $urandom,
                       4'($urandom), "rnd_wr_pre");
                4: bus(1, 7'h02, 32'($urandom_range(0, 3)), 4'($urandom), "rnd_wr_set");
                5: bus(1, 7'h04, 32'($urandom_range(0, 3)), 4'($urandom), "rnd_wr_err");
                6: bus(1, 7'h06, $urandom, 4'($urandom), "rnd_wr_dbg");
                default: begin
                    op = $urandom_range(0, 2);
                    a = (op == 2) ? 7'($urandom_range(7, 127)) : 7'(op);
                    bus(1, a, $urandom, 4'($urandom), "rnd_wr_ill");
                end
            endcase
            idle($urandom_range(0, 3));
        end

        bus(1, 7'h06, 32'hA5A5_5A5A, 4'hF, "wr_dbg_pre_rst");
        bus(1, 7'h03, 32'h1, 4'hF, "wr_en_pre_rst");
        idle(4);
        WBs_ADR = 7'h06; WBs_WE = 0; WBs_CYC = 1; WBs_STB = 1;
        @(posedge WB_CLK); #2;
        chk_now("ack_before_rst", 32'(WBs_ACK), 32'd1);
        WB_RST_N = 0;
        #1;
        chk_now("midrst_ack", 32'(WBs_ACK), 32'd0);
        chk_now("midrst_rd_dat", WBs_RD_DAT, 32'd0);
        chk_now("midrst_count", count, 32'd0);
        WBs_CYC = 0; WBs_STB = 0;
        @(posedge WB_CLK); #1;
        WB_RST_N = 1;
        reset_model();
        bus(0, 7'h03, 0, 4'hF, "post_rst_en");
        bus(0, 7'h04, 0, 4'hF, "post_rst_err");
        bus(0, 7'h06, 0, 4'hF, "post_rst_dbg");
        bus(0, 7'h05, 0, 4'hF, "post_rst_cnt");

        idle(3);
        chk_now("sb_drain", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
